// File: rtl/bit_xor_pkg.sv
// Shared types and default sizing for the XOR checker block.
package bit_xor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WINDOW_DEF = 16;
  localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clr_in,
  input  logic             inc_in,
  output logic [WIDTH-1:0] count_out
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0] r_count;

  // NOTE: reset is synchronous here, so it sits inside the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk_in) begin
    if (rst_in || clr_in) begin
      r_count <= '0;
    end else if (inc_in && (r_count != MAX_VAL)) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count_out = r_count;

endmodule

// File: rtl/bit_xor_checker.sv
// Checks a window of valid (a, b, y) samples for y == a ^ b and reports errors.
// Build option: define XOR_CHK_STOP_ON_ERR_EN to end the window on the first mismatch.
module bit_xor_checker
  import bit_xor_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             valid_in,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             y_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             pass_out,
  output logic [CNT_W-1:0] err_cnt_out,
  output logic [CNT_W-1:0] first_err_idx_out
);

  localparam int               SMP_W      = $clog2(WINDOW);
  localparam logic [SMP_W-1:0] LAST_IDX   = SMP_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] NO_ERR_IDX = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_mismatch;
  logic             w_stop;
  logic             w_sample;
  logic             w_clr;
  logic [CNT_W-1:0] w_err_cnt;
  logic [SMP_W-1:0] w_smp_cnt;
  logic             r_pass;
  logic [CNT_W-1:0] r_first_err_idx;

  assign w_mismatch = y_in ^ (a_in ^ b_in);

`ifdef XOR_CHK_STOP_ON_ERR_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start_in) begin
          w_state_nxt = RUN;
          w_clr       = 1'b1;
        end
      end
      RUN: begin
        if (valid_in) begin
          w_sample = 1'b1;
          if ((w_smp_cnt == LAST_IDX) || w_stop) begin
            w_state_nxt = DONE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .clr_in    (w_clr),
    .inc_in    (w_sample && w_mismatch),
    .count_out (w_err_cnt)
  );

  // Sample index is sized from WINDOW so a narrow CNT_W never shortens the window.
  sat_counter #(.WIDTH(SMP_W)) u_smp_cnt (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .clr_in    (w_clr),
    .inc_in    (w_sample),
    .count_out (w_smp_cnt)
  );

  // Error counter never wraps, so zero reliably means no mismatch yet this window.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_pass          <= 1'b0;
      r_first_err_idx <= NO_ERR_IDX;
    end else if (w_clr) begin
      r_pass          <= 1'b0;
      r_first_err_idx <= NO_ERR_IDX;
    end else if (w_sample) begin
      if (w_mismatch && (w_err_cnt == '0)) begin
        r_first_err_idx <= CNT_W'(w_smp_cnt);
      end
      if (w_state_nxt == DONE) begin
        r_pass <= (w_err_cnt == '0) && !w_mismatch;
      end
    end
  end

  assign busy_out          = (r_state == RUN);
  assign done_out          = (r_state == DONE);
  assign pass_out          = r_pass;
  assign err_cnt_out       = w_err_cnt;
  assign first_err_idx_out = r_first_err_idx;

endmodule

// File: tb/tb_bit_xor_checker.sv
// Randomized bench for bit_xor_checker: a window-history model predicts every output each cycle.
module tb_bit_xor_checker;

  localparam int WINDOW = 16;
  localparam int CNT_W  = 8;
  localparam int CNT_W2 = 2;
`ifdef XOR_CHK_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_in, start_in, valid_in, a_in, b_in, y_in;

  logic              busy_out, done_out, pass_out;
  logic [CNT_W-1:0]  err_cnt_out, first_err_idx_out;
  logic              w2_busy, w2_done, w2_pass;
  logic [CNT_W2-1:0] w2_err_cnt, w2_first_err_idx;

  always #5 clk_in = ~clk_in;

  bit_xor_checker #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .start_in          (start_in),
    .valid_in          (valid_in),
    .a_in              (a_in),
    .b_in              (b_in),
    .y_in              (y_in),
    .busy_out          (busy_out),
    .done_out          (done_out),
    .pass_out          (pass_out),
    .err_cnt_out       (err_cnt_out),
    .first_err_idx_out (first_err_idx_out)
  );

  bit_xor_checker #(.WINDOW(WINDOW), .CNT_W(CNT_W2)) dut_w2 (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .start_in          (start_in),
    .valid_in          (valid_in),
    .a_in              (a_in),
    .b_in              (b_in),
    .y_in              (y_in),
    .busy_out          (w2_busy),
    .done_out          (w2_done),
    .pass_out          (w2_pass),
    .err_cnt_out       (w2_err_cnt),
    .first_err_idx_out (w2_first_err_idx)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode plus the mismatch history of the current window.
  typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_t;
  mstate_t ms = M_IDLE;
  bit      mq[$];

  function automatic int q_errs();
    int s = 0;
    foreach (mq[i]) s += int'(mq[i]);
    return s;
  endfunction

  function automatic int q_first();
    foreach (mq[i]) if (mq[i]) return i;
    return -1;
  endfunction

  task automatic model_edge();
    bit mis;
    if (rst_in) begin
      ms = M_IDLE;
      mq.delete();
    end else if (ms != M_RUN) begin
      if (start_in) begin
        ms = M_RUN;
        mq.delete();
      end
    end else if (valid_in) begin
      mis = (y_in != (a_in ^ b_in));
      mq.push_back(mis);
      if ((mq.size() == WINDOW) || (STOP && mis)) ms = M_DONE;
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic step(input string ctx);
    int e, f;
    model_edge();
    @(posedge clk_in);
    #1;
    e = q_errs();
    f = q_first();
    check({ctx, ".busy"},  32'(busy_out),          32'(ms == M_RUN));
    check({ctx, ".done"},  32'(done_out),          32'(ms == M_DONE));
    check({ctx, ".pass"},  32'(pass_out),          32'((ms == M_DONE) && (e == 0)));
    check({ctx, ".err"},   32'(err_cnt_out),       32'(sat(e, CNT_W)));
    check({ctx, ".first"}, 32'(first_err_idx_out), (f < 0) ? 32'hFF : 32'(f));
    check({ctx, ".w2err"}, 32'(w2_err_cnt),        32'(sat(e, CNT_W2)));
    check({ctx, ".w2done"}, 32'(w2_done),          32'(ms == M_DONE));
    if (f < 3) check({ctx, ".w2first"}, 32'(w2_first_err_idx), (f < 0) ? 32'd3 : 32'(f));
  endtask

  task automatic drive_idle();
    rst_in   = 1'b0;
    start_in = 1'b0;
    valid_in = 1'($urandom);
    a_in     = 1'($urandom);
    b_in     = 1'($urandom);
    y_in     = 1'($urandom);
  endtask

  // vmode: 0 always valid, 1 alternate 1/0, 2 random. rst_at: sample index to reset on (-1 none).
  task automatic run_window(input string ctx, input logic [WINDOW-1:0] err_mask,
                            input int vmode, input int rst_at);
    int cyc;
    int idx;
    int limit;
    cyc   = 0;
    limit = 4 * WINDOW + 8;
    drive_idle();
    start_in = 1'b1;
    step({ctx, ".start"});
    while ((ms == M_RUN) && (cyc < limit)) begin
      idx = mq.size();
      case (vmode)
        0:       valid_in = 1'b1;
        1:       valid_in = ((cyc % 2) == 0);
        default: valid_in = ($urandom_range(0, 3) != 0);
      endcase
      a_in     = 1'($urandom);
      b_in     = 1'($urandom);
      y_in     = valid_in ? (a_in ^ b_in ^ err_mask[idx]) : 1'($urandom);
      start_in = ($urandom_range(0, 3) == 0);
      rst_in   = (rst_at >= 0) && (idx == rst_at);
      step(ctx);
      cyc++;
    end
    check({ctx, ".bound"}, 32'(cyc < limit), 32'd1);
    repeat (3) begin
      drive_idle();
      step({ctx, ".hold"});
    end
  endtask

  initial begin
    rst_in   = 1'b1;
    start_in = 1'b1;
    valid_in = 1'b1;
    a_in     = 1'b0;
    b_in     = 1'b0;
    y_in     = 1'b1;
    repeat (2) step("reset");

    run_window("clean",     16'h0000, 0, -1);
    run_window("err3_9",    16'h0208, 0, -1);
    run_window("toggle",    16'h0000, 1, -1);
    run_window("rst7",      16'h0012, 0, 7);
    run_window("after_rst", 16'h0000, 0, -1);
    run_window("all_wrong", 16'hFFFF, 0, -1);
    run_window("err5",      16'h0020, 0, -1);
    for (int i = 0; i < 8; i++) begin
      run_window("rand", 16'($urandom & $urandom & $urandom), 2, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
